// File: rtl/button_pio_pkg.sv
// Shared constants for the debounced button PIO: register map, prescaler
// reset default and the width helper used to size the per-channel counters.
package button_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_RAW     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_DIV     = 3'd6;

    localparam logic [15:0] DIV_RST_DEFAULT = 16'd49999;

    // Bits needed to hold values 0..value-1; at least 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: input synchroniser, tick-qualified debounce counter
// and the debounced stable level, with its next value exported for edge detection.
module button_debounce
    import button_pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_TICKS    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    input  logic tick_i,
    output logic raw_o,
    output logic stable_o,
    output logic stable_d_o
);

    localparam int CW = clog2(DB_TICKS + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign raw_o = sync_q[SYNC_STAGES-1];

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (raw_o == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CW'(DB_TICKS - 1)) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign stable_o   = stable_q;
    assign stable_d_o = stable_d;

endmodule

// File: rtl/button_pio_db.sv
// Debounced button PIO with Avalon-MM register access, shared prescaler,
// per-channel edge capture (W1C) and a masked level interrupt.
module button_pio_db
    import button_pio_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          DB_TICKS    = 4,
    parameter logic [15:0] DIV_RST     = DIV_RST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             wr_en, div_wr, tick;
    logic [15:0]      presc_q, presc_d, div_q;
    logic [WIDTH-1:0] raw, stable, stable_nx, rise, fall, cap_set, cap_clr;
    logic [WIDTH-1:0] mask_q, cap_q, cap_d, rise_en_q, fall_en_q;
    logic [31:0]      rdata_d;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign div_wr       = wr_en && (address == ADDR_DIV);
    assign unused_wdata = ^writedata;

    // A DIV write restarts the count and swallows the tick of that cycle.
    assign tick    = (presc_q >= div_q) && !div_wr;
    assign presc_d = (div_wr || presc_q >= div_q) ? 16'd0 : presc_q + 16'd1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_TICKS   (DB_TICKS)
        ) u_db (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_i      (in_port[i]),
            .tick_i    (tick),
            .raw_o     (raw[i]),
            .stable_o  (stable[i]),
            .stable_d_o(stable_nx[i])
        );
    end

    assign rise    = stable_nx & ~stable;
    assign fall    = ~stable_nx & stable;
    assign cap_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign cap_clr = (wr_en && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
    // Set is applied after the clear so a coincident edge is never lost.
    assign cap_d   = (cap_q & ~cap_clr) | cap_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            div_q     <= DIV_RST;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '1;
            cap_q     <= '0;
            readdata  <= '0;
        end else begin
            presc_q  <= presc_d;
            cap_q    <= cap_d;
            readdata <= rdata_d;
            if (div_wr) div_q <= writedata[15:0];
            if (wr_en && address == ADDR_MASK)    mask_q    <= writedata[WIDTH-1:0];
            if (wr_en && address == ADDR_RISE_EN) rise_en_q <= writedata[WIDTH-1:0];
            if (wr_en && address == ADDR_FALL_EN) fall_en_q <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:    rdata_d[WIDTH-1:0] = stable;
            ADDR_RAW:     rdata_d[WIDTH-1:0] = raw;
            ADDR_MASK:    rdata_d[WIDTH-1:0] = mask_q;
            ADDR_CAPTURE: rdata_d[WIDTH-1:0] = cap_q;
            ADDR_RISE_EN: rdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN: rdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_DIV:     rdata_d[15:0]      = div_q;
            default:      rdata_d            = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_button_pio_db.sv
// Scoreboard bench for button_pio_db: probes push expected register/irq values,
// a monitor pops and compares one cycle later when the registered read lands.
module tb_button_pio_db;
    import button_pio_pkg::*;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port = '1;
    logic             irq;

    always #5 clk = ~clk;

    button_pio_db #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .DB_TICKS   (4),
        .DIV_RST    (16'd49999)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic probe_req  = 1'b0;
    logic probe_pend = 1'b0;
    int   checks     = 0;
    int   failures   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) probe_pend <= 1'b0;
        else          probe_pend <= probe_req;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (probe_pend) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow actual=empty expected=entry at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check(e.name, e.is_irq ? {31'b0, irq} : readdata, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.is_irq = 1'b0;
        e.exp    = exp;
        e.name   = name;
        sb_q.push_back(e);
        address   = a;
        probe_req = 1'b1;
        step();
        probe_req = 1'b0;
    endtask

    task automatic probe_irq(input logic exp, input string name);
        exp_t e;
        e.is_irq = 1'b1;
        e.exp    = {31'b0, exp};
        e.name   = name;
        sb_q.push_back(e);
        probe_req = 1'b1;
        step();
        probe_req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        probe_rd(ADDR_DATA,    32'h0,     "rst_data");
        probe_rd(ADDR_MASK,    32'h0,     "rst_mask");
        probe_rd(ADDR_CAPTURE, 32'h0,     "rst_capture");
        probe_rd(ADDR_RISE_EN, 32'h0,     "rst_rise_en");
        probe_rd(ADDR_FALL_EN, 32'hF,     "rst_fall_en");
        probe_rd(ADDR_DIV,     32'd49999, "rst_div");
        probe_rd(3'd7,         32'h0,     "reserved_reads_zero");
        probe_irq(1'b0, "rst_irq");
        probe_rd(ADDR_RAW,     32'hF,     "raw_after_sync");

        // Idle-high inputs debounce to 1; the rise is not captured by default
        wr(ADDR_DIV, 32'd0);
        repeat (12) step();
        probe_rd(ADDR_DATA,    32'hF, "powerup_data");
        probe_rd(ADDR_CAPTURE, 32'h0, "powerup_no_capture");

        // Channel 0 falls; capture lands exactly SYNC_STAGES+4 edges later
        in_port[0] = 1'b0;
        repeat (5) step();
        probe_rd(ADDR_CAPTURE, 32'h0, "fall_cap_edge6_pre");
        probe_rd(ADDR_CAPTURE, 32'h1, "fall_cap_edge6_post");
        probe_rd(ADDR_DATA,    32'hE, "fall_data");
        probe_irq(1'b0, "irq_masked");
        wr(ADDR_MASK, 32'h1);
        probe_irq(1'b1, "irq_unmasked");

        // 3-cycle glitch on channel 1 must be filtered
        in_port[1] = 1'b0;
        repeat (3) step();
        in_port[1] = 1'b1;
        repeat (10) step();
        probe_rd(ADDR_DATA,    32'hE, "glitch_data");
        probe_rd(ADDR_CAPTURE, 32'h1, "glitch_capture");
        probe_irq(1'b1, "glitch_irq");

        // Simultaneous rises on channels 0 and 2
        wr(ADDR_FALL_EN, 32'h0);
        wr(ADDR_RISE_EN, 32'hF);
        in_port[2] = 1'b0;
        repeat (10) step();
        wr(ADDR_CAPTURE, 32'hF);
        probe_rd(ADDR_CAPTURE, 32'h0, "cap_cleared");
        probe_rd(ADDR_DATA,    32'hA, "pre_multi_data");
        in_port[0] = 1'b1;
        in_port[2] = 1'b1;
        repeat (5) step();
        probe_rd(ADDR_CAPTURE, 32'h0, "multi_cap_pre");
        probe_rd(ADDR_CAPTURE, 32'h5, "multi_cap_same_cycle");
        probe_rd(ADDR_DATA,    32'hF, "multi_data");

        // W1C behaviour and set-beats-clear
        wr(ADDR_CAPTURE, 32'hF);
        wr(ADDR_FALL_EN, 32'hF);
        in_port[0] = 1'b0;
        in_port[1] = 1'b0;
        repeat (10) step();
        probe_rd(ADDR_CAPTURE, 32'h3, "two_falls");
        wr(ADDR_CAPTURE, 32'h1);
        probe_rd(ADDR_CAPTURE, 32'h2, "w1c_bit0_only");
        wr(ADDR_CAPTURE, 32'h2);
        probe_rd(ADDR_CAPTURE, 32'h0, "w1c_bit1");
        in_port[1] = 1'b1;
        repeat (5) step();
        wr(ADDR_CAPTURE, 32'h2);
        probe_rd(ADDR_CAPTURE, 32'h2, "set_beats_clear");
        wr(ADDR_CAPTURE, 32'hF);
        probe_rd(ADDR_CAPTURE, 32'h0, "cap_clean");

        // DIV=9: four ticks of 10 cycles
        wr(ADDR_DIV, 32'd9);
        in_port[3] = 1'b0;
        repeat (39) step();
        probe_rd(ADDR_DATA, 32'hE, "div9_edge40_pre");
        probe_rd(ADDR_DATA, 32'h6, "div9_edge40_post");
        probe_rd(ADDR_DIV,  32'd9, "div_readback");

        // Rewriting DIV mid-count restarts the prescaler
        wr(ADDR_DIV, 32'd9);
        in_port[2] = 1'b0;
        repeat (5) step();
        wr(ADDR_DIV, 32'd9);
        repeat (39) step();
        probe_rd(ADDR_DATA, 32'h6, "restart_pre");
        probe_rd(ADDR_DATA, 32'h2, "restart_post");

        // Asynchronous reset in the middle of a debounce
        wr(ADDR_MASK, 32'hF);
        probe_irq(1'b1, "pre_reset_irq");
        in_port[1] = 1'b0;
        repeat (15) step();
        reset_n = 1'b0;
        #2;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        probe_rd(ADDR_FALL_EN, 32'hF,     "rst2_fall_en");
        probe_rd(ADDR_DIV,     32'd49999, "rst2_div");
        probe_rd(ADDR_MASK,    32'h0,     "rst2_mask");
        probe_rd(ADDR_CAPTURE, 32'h0,     "rst2_capture");
        probe_rd(ADDR_RISE_EN, 32'h0,     "rst2_rise_en");
        probe_rd(ADDR_DATA,    32'h0,     "rst2_data");
        probe_irq(1'b0, "rst2_irq");

        repeat (3) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_pio_db.md
BUTTON_PIO_DB -- requirements
Module: button_pio_db

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-003 SHALL have parameter DB_TICKS, default 4, consecutive prescaler ticks an input must differ from its stable value before the stable value changes (1..255).
REQ-004 SHALL have parameter DIV_RST, default 49999, reset value of the prescaler divisor (16-bit).
REQ-005 SHALL have port clk, input, 1, the only clock; all flops are on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have ports address input 3, chipselect input 1, write_n input 1 (active-low), writedata input 32, which form the Avalon-MM slave write side.
REQ-008 SHALL have port readdata, output, 32, registered read data.
REQ-009 SHALL have port in_port, input, WIDTH, asynchronous raw button levels.
REQ-010 SHALL have port irq, output, 1, level interrupt.

Function
REQ-011 SHALL use this register map (bits above WIDTH read 0, ignored on write): 0 DATA RO debounced state; 1 RAW RO synchronised input; 2 MASK RW; 3 CAPTURE W1C; 4 RISE_EN RW; 5 FALL_EN RW; 6 DIV RW [15:0]; 7 reserved, reads 0.
REQ-012 SHALL update readdata every cycle from address, regardless of chipselect, so read latency is 1 cycle.
REQ-013 SHALL perform a write only when chipselect=1 and write_n=0; the new value is visible from the next cycle.
REQ-014 SHALL pass each in_port bit through SYNC_STAGES flops; the last stage is RAW.
REQ-015 SHALL run a 16-bit prescaler that counts 0..DIV and emits a 1-cycle tick on wrap; DIV=0 gives a tick every cycle.
REQ-016 SHALL reset the prescaler count to 0 and drop any pending tick when DIV is written.
REQ-017 SHALL keep, per channel, a stable bit and a tick counter of width clog2(DB_TICKS+1).
REQ-018 SHALL clear a channel's counter immediately when RAW equals stable, with or without a tick.
REQ-019 SHALL increment a channel's counter on each tick while RAW differs from stable; on the tick that reaches DB_TICKS, stable SHALL toggle and the counter SHALL clear in the same cycle.
REQ-020 SHALL never let a glitch shorter than DB_TICKS ticks change stable.
REQ-021 SHALL derive rise = stable_next & ~stable and fall = ~stable_next & stable as 1-cycle pulses aligned with the stable update.
REQ-022 SHALL set CAPTURE[i] when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
REQ-023 SHALL clear CAPTURE[i] on a write to address 3 with writedata[i]=1; writedata[i]=0 leaves the bit unchanged.
REQ-024 SHALL let the set win when a set and a W1C clear of the same bit occur in the same cycle, so no edge is lost.
REQ-025 SHALL drive irq = |(CAPTURE & MASK), combinational from registers with no added latency; irq asserts the cycle after the capture bit sets.
REQ-026 SHALL have MASK and enable writes that gate irq and capture only; they SHALL NOT alter existing CAPTURE bits.
REQ-027 SHALL have channels that are fully independent; simultaneous edges on several channels all capture in the same cycle.

Reset
REQ-028 SHALL, on reset_n low, asynchronously clear all synchroniser flops, stable bits, counters, CAPTURE, MASK, RISE_EN, the prescaler count and readdata.
REQ-029 SHALL reset FALL_EN to all ones (active-low buttons) and DIV to DIV_RST.
REQ-030 SHALL release reset with no spurious capture; a high input after reset produces a rise that is not captured with the default enables.

Structure
REQ-031 SHALL place the register address constants (ADDR_DATA..ADDR_DIV), the default DIV_RST and the clog2 helper in the shared package button_pio_pkg.
REQ-032 SHALL implement the per-channel synchroniser, counter and stable bit as sub-module button_debounce, instantiated WIDTH times; the prescaler, registers and Avalon decode SHALL live in the top level.

Verification
REQ-033 SHALL cover: DIV=0, DB_TICKS=4, in_port[0] 1->0 held for 10 cycles -> DATA[0]=0 and CAPTURE=0x1 exactly SYNC_STAGES+4 cycles after the edge; irq=1 once MASK=0x1.
REQ-034 SHALL cover: DIV=0, in_port[1] low for 3 cycles then high -> DATA, CAPTURE and irq unchanged.
REQ-035 SHALL cover: RISE_EN=0xF, FALL_EN=0x0, channels 0 and 2 rising together -> CAPTURE=0x5 in the same cycle.
REQ-036 SHALL cover: CAPTURE=0x3, write 0x1 to address 3 -> CAPTURE=0x2; a W1C of bit 1 on the cycle its new edge sets -> bit 1 remains 1.
REQ-037 SHALL cover: DIV=9, edge held -> stable changes after 40±10 cycles; writing DIV mid-count restarts the prescaler from 0.
REQ-038 SHALL cover: reset_n low mid-debounce -> all registers at reset values immediately, FALL_EN=0xF, DIV=DIV_RST, irq=0.
